pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline. It sits beside the decode-stage control decoder and drives the write-enable and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It covers four situations: the post-reset boot window, load-use hazards, taken branches resolved in ID, and data-memory wait handshakes. It also provides saturating performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the
// central stall/flush sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       id_op_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_branch_taken_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             memwb_bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             mem_timeout_o;

  modport master (
    output id_op_i, id_rs1_i, id_rs2_i,
    output id_branch_taken_i,
    output ex_memread_i, ex_rd_i,
    output mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o,
    input  ifid_flush_o, idex_write_o,
    input  idex_bubble_o, exmem_write_o,
    input  memwb_bubble_o, state_o,
    input  stall_cnt_o, flush_cnt_o,
    input  mem_timeout_o
  );

  modport slave (
    input  id_op_i, id_rs1_i, id_rs2_i,
    input  id_branch_taken_i,
    input  ex_memread_i, ex_rd_i,
    input  mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o,
    output ifid_flush_o, idex_write_o,
    output idex_bubble_o, exmem_write_o,
    output memwb_bubble_o, state_o,
    output stall_cnt_o, flush_cnt_o,
    output mem_timeout_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: boot window,
// load-use, ID branch flush, data-memory wait, perf counters.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic clk_i,
  input logic rst_n_i,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int BW = (BOOT_CYCLES > 1) ?
                      $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [BW-1:0]    boot_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             timeout;

  logic rs1_used;
  logic rs2_used;
  logic load_use;
  logic mem_stall;

  logic pc_w;
  logic ifid_w;
  logic ifid_f;
  logic idex_w;
  logic idex_b;
  logic exmem_w;
  logic memwb_b;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (hz.id_op_i)
      7'b0110011,
      7'b0100011,
      7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b0000011,
      7'b0010011: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = hz.ex_memread_i &&
                    (hz.ex_rd_i != 5'd0) &&
                    ((rs1_used && hz.ex_rd_i == hz.id_rs1_i) ||
                     (rs2_used && hz.ex_rd_i == hz.id_rs2_i));

  assign mem_stall = hz.mem_req_i && !hz.mem_ready_i;

  // Freeze outranks load-use, which outranks the branch flush.
  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_b  = 1'b0;
    exmem_w = 1'b1;
    memwb_b = 1'b0;
    if (state == INIT) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      ifid_f = 1'b1;
      idex_b = 1'b1;
    end else if (mem_stall) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_b = 1'b1;
    end else if (load_use) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_b = 1'b1;
    end else if (hz.id_branch_taken_i) begin
      ifid_f = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= INIT;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (boot_cnt == BW'(BOOT_CYCLES - 1))
            state <= RUN;
          else
            boot_cnt <= boot_cnt + BW'(1);
        end
        default: begin
          state <= mem_stall ? MEM_WAIT : RUN;
          if (wait_cnt == WW'(MEM_TIMEOUT))
            timeout <= 1'b1;
          if (!mem_stall)
            wait_cnt <= '0;
          else if (wait_cnt != WW'(MEM_TIMEOUT))
            wait_cnt <= wait_cnt + WW'(1);
          if (!pc_w && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
          if (ifid_f && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
      endcase
    end
  end

  assign hz.pc_write_o     = pc_w;
  assign hz.ifid_write_o   = ifid_w;
  assign hz.ifid_flush_o   = ifid_f;
  assign hz.idex_write_o   = idex_w;
  assign hz.idex_bubble_o  = idex_b;
  assign hz.exmem_write_o  = exmem_w;
  assign hz.memwb_bubble_o = memwb_b;
  assign hz.state_o        = state;
  assign hz.stall_cnt_o    = stall_cnt;
  assign hz.flush_cnt_o    = flush_cnt;
  assign hz.mem_timeout_o  = timeout;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against
// an event-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int BOOT = 2;
  localparam int MT   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES(BOOT),
    .MEM_TIMEOUT(MT),
    .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .hz(hz_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode;
  int m_boot;
  int m_consec;
  int m_stalls;
  int m_flushes;
  bit m_to;

  logic [6:0] ops [8] = '{7'b0110011, 7'b0000011,
                          7'b0100011, 7'b1100011,
                          7'b0010011, 7'b0110111,
                          7'b1101111, 7'b1110011};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit ref_load_use();
    bit r1, r2;
    r1 = hz_if.id_op_i inside {7'b0110011, 7'b0000011,
           7'b0100011, 7'b1100011, 7'b0010011};
    r2 = hz_if.id_op_i inside {7'b0110011, 7'b0100011,
           7'b1100011};
    if (!hz_if.ex_memread_i || hz_if.ex_rd_i == 0) return 0;
    return (r1 && hz_if.ex_rd_i == hz_if.id_rs1_i) ||
           (r2 && hz_if.ex_rd_i == hz_if.id_rs2_i);
  endfunction

  task automatic model_reset();
    m_mode    = 0;
    m_boot    = 0;
    m_consec  = 0;
    m_stalls  = 0;
    m_flushes = 0;
    m_to      = 0;
  endtask

  task automatic set_idle();
    hz_if.id_op_i           = 7'b0010011;
    hz_if.id_rs1_i          = 5'd0;
    hz_if.id_rs2_i          = 5'd0;
    hz_if.id_branch_taken_i = 1'b0;
    hz_if.ex_memread_i      = 1'b0;
    hz_if.ex_rd_i           = 5'd0;
    hz_if.mem_req_i         = 1'b0;
    hz_if.mem_ready_i       = 1'b1;
  endtask

  // Control word: pc, ifid_w, ifid_flush, idex_w, idex_bub, exmem, memwb_bub
  task automatic step();
    logic [6:0] ctl;
    bit st, lu;
    @(negedge clk);
    st = hz_if.mem_req_i && !hz_if.mem_ready_i;
    lu = ref_load_use();
    if (m_mode == 0)                 ctl = 7'b0011110;
    else if (st)                     ctl = 7'b0000001;
    else if (lu)                     ctl = 7'b0001110;
    else if (hz_if.id_branch_taken_i) ctl = 7'b1111010;
    else                             ctl = 7'b1101010;
    check("ctl", {hz_if.pc_write_o, hz_if.ifid_write_o,
                  hz_if.ifid_flush_o, hz_if.idex_write_o,
                  hz_if.idex_bubble_o, hz_if.exmem_write_o,
                  hz_if.memwb_bubble_o}, ctl);
    check("state", hz_if.state_o, m_mode);
    check("stall_cnt", hz_if.stall_cnt_o, sat(m_stalls));
    check("flush_cnt", hz_if.flush_cnt_o, sat(m_flushes));
    check("timeout", hz_if.mem_timeout_o, m_to);
    @(posedge clk);
    if (rst_n) begin
      if (m_mode == 0) begin
        m_boot++;
        if (m_boot == BOOT) m_mode = 1;
      end else begin
        if (st || lu) m_stalls++;
        if (!st && !lu && hz_if.id_branch_taken_i) m_flushes++;
        if (m_consec >= MT) m_to = 1;
        m_consec = st ? m_consec + 1 : 0;
        m_mode = st ? 2 : 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    set_idle();
    model_reset();
    #1;
    do_reset();
    check("boot_run", hz_if.state_o, 1);
    step();

    hz_if.ex_memread_i      = 1'b1;
    hz_if.ex_rd_i           = 5'd5;
    hz_if.id_op_i           = 7'b0110011;
    hz_if.id_rs1_i          = 5'd1;
    hz_if.id_rs2_i          = 5'd5;
    hz_if.id_branch_taken_i = 1'b1;
    step();
    check("lu_cnt", hz_if.stall_cnt_o, 1);
    hz_if.ex_memread_i = 1'b0;
    hz_if.id_branch_taken_i = 1'b0;
    step();
    hz_if.ex_memread_i = 1'b1;
    hz_if.ex_rd_i      = 5'd0;
    hz_if.id_rs2_i     = 5'd0;
    step();
    hz_if.ex_rd_i  = 5'd5;
    hz_if.id_rs2_i = 5'd5;
    hz_if.id_op_i  = 7'b0010011;
    step();
    check("imm_nostall", hz_if.stall_cnt_o, 1);
    set_idle();
    hz_if.id_branch_taken_i = 1'b1;
    step();
    check("br_flush", hz_if.flush_cnt_o, 1);
    set_idle();
    step();

    do_reset();
    hz_if.mem_req_i         = 1'b1;
    hz_if.mem_ready_i       = 1'b0;
    hz_if.id_branch_taken_i = 1'b1;
    repeat (3) step();
    check("mw_state", hz_if.state_o, 2);
    hz_if.mem_ready_i = 1'b1;
    step();
    check("mw_stall", hz_if.stall_cnt_o, 3);
    check("mw_flush", hz_if.flush_cnt_o, 1);
    set_idle();
    step();

    do_reset();
    hz_if.mem_req_i   = 1'b1;
    hz_if.mem_ready_i = 1'b0;
    repeat (3) step();
    check("to_early", hz_if.mem_timeout_o, 0);
    repeat (4) step();
    check("to_set", hz_if.mem_timeout_o, 1);
    hz_if.mem_ready_i = 1'b1;
    repeat (2) step();
    check("to_sticky", hz_if.mem_timeout_o, 1);
    hz_if.mem_ready_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_state", hz_if.state_o, 0);
    check("rst_to", hz_if.mem_timeout_o, 0);
    check("rst_stall", hz_if.stall_cnt_o, 0);
    step();
    rst_n = 1'b1;
    step();
    step();

    do_reset();
    hz_if.ex_memread_i = 1'b1;
    hz_if.ex_rd_i      = 5'd3;
    hz_if.id_op_i      = 7'b0000011;
    hz_if.id_rs1_i     = 5'd3;
    repeat (10) step();
    check("sat7", hz_if.stall_cnt_o, 7);
    set_idle();

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end
      hz_if.id_op_i           = ops[$urandom_range(0, 7)];
      hz_if.id_rs1_i          = 5'($urandom_range(0, 3));
      hz_if.id_rs2_i          = 5'($urandom_range(0, 3));
      hz_if.id_branch_taken_i = 1'($urandom_range(0, 1));
      hz_if.ex_memread_i      = 1'($urandom_range(0, 1));
      hz_if.ex_rd_i           = 5'($urandom_range(0, 3));
      hz_if.mem_req_i         = 1'($urandom_range(0, 1));
      hz_if.mem_ready_i       = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
